// File: rtl/util_cpack2_timestamp_pkg.sv
// Shared definitions for the RX timestamp inserter: state encodings and widths.
// Optional feature macro used by the top: UTIL_CPACK2_TS_DROP_COUNT_EN.
package util_cpack2_timestamp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_BLOCK_START = 2'd1,
        ST_IN_BLOCK    = 2'd2
    } ts_state_t;

    localparam int TS_WORD_WIDTH  = 64;
    localparam int DROP_CNT_WIDTH = 16;

endpackage

// File: rtl/util_cpack2_timestamp_fifo.sv
// Register-array FIFO: accepts 0, 1 or 2 words per cycle, delivers 1 per cycle.
// The caller must never request more writes than free_o allows.
module util_cpack2_timestamp_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [1:0]            wr_cnt_i,
    input  logic [DATA_WIDTH-1:0] wr_data0_i,
    input  logic [DATA_WIDTH-1:0] wr_data1_i,
    input  logic                  rd_en_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [CW-1:0]         free_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  rd_fire;

    assign rd_fire   = rd_en_i && (count_q != '0);
    assign valid_o   = (count_q != '0);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign free_o    = CW'(DEPTH) - count_q;

    // Storage, pointers and occupancy; a flush empties the queue but keeps contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_cnt_i != 2'd0) mem_q[wr_ptr_q] <= wr_data0_i;
            if (wr_cnt_i == 2'd2) mem_q[wr_ptr_q + AW'(1)] <= wr_data1_i;
            wr_ptr_q <= wr_ptr_q + AW'(wr_cnt_i);
            rd_ptr_q <= rd_ptr_q + AW'(rd_fire);
            count_q  <= count_q + CW'(wr_cnt_i) - CW'(rd_fire);
        end
    end

endmodule

// File: rtl/util_cpack2_timestamp.sv
// Inserts a timestamp word ahead of every block of timestamp_every packed words
// on the cpack -> ADC DMA path. Words that do not fit in the output FIFO are dropped.
// Define UTIL_CPACK2_TS_DROP_COUNT_EN to add the saturating drop_count output.
module util_cpack2_timestamp
    import util_cpack2_timestamp_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int FIFO_DEPTH     = 8,
    parameter int TS_EVERY_WIDTH = 32
) (
    input  logic                      adc_clk,
    input  logic                      adc_resetn,
    input  logic [TS_EVERY_WIDTH-1:0] timestamp_every,
    input  logic [TS_WORD_WIDTH-1:0]  timestamp,
    input  logic                      fifo_wr_en,
    input  logic [DATA_WIDTH-1:0]     fifo_wr_data,
    output logic                      fifo_wr_overflow,
    input  logic                      m_axis_xfer_req,
    output logic                      m_axis_valid,
    input  logic                      m_axis_ready,
    output logic [DATA_WIDTH-1:0]     m_axis_data
`ifdef UTIL_CPACK2_TS_DROP_COUNT_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Output handshake: a word moves when m_axis_valid && m_axis_ready are both high.
    ts_state_t                 state_q, state_d;
    logic [TS_EVERY_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [TS_EVERY_WIDTH-1:0] every_q, every_d;
    logic                      xfer_q;
    logic                      overflow_q;

    logic                      xfer_rise;
    logic                      active;
    logic                      at_start;
    logic                      ins_ts;
    logic [1:0]                need;
    logic                      accept;
    logic                      drop;
    logic [1:0]                wr_cnt;
    logic [CW-1:0]             free;
    logic [TS_EVERY_WIDTH-1:0] every_eff;
    logic [TS_EVERY_WIDTH-1:0] cnt_inc;

    assign xfer_rise = m_axis_xfer_req && !xfer_q;
    assign active    = m_axis_xfer_req && (state_q != ST_IDLE);
    assign at_start  = (state_q == ST_BLOCK_START);
    assign ins_ts    = at_start && (timestamp_every != '0);
    assign need      = ins_ts ? 2'd2 : 2'd1;
    // Free count is taken before this cycle's pop, so a full FIFO being drained still drops.
    assign accept    = active && fifo_wr_en && (free >= CW'(need));
    assign drop      = active && fifo_wr_en && (free < CW'(need));
    assign wr_cnt    = accept ? need : 2'd0;
    assign every_eff = at_start ? timestamp_every : every_q;
    assign cnt_inc   = at_start ? TS_EVERY_WIDTH'(1) : word_cnt_q + TS_EVERY_WIDTH'(1);

    // Next-state decode for the block sequencer and word counter.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        every_d    = every_q;
        if (!m_axis_xfer_req) begin
            state_d    = ST_IDLE;
            word_cnt_d = '0;
        end else if (state_q == ST_IDLE) begin
            state_d    = ST_BLOCK_START;
            word_cnt_d = '0;
        end else if (drop) begin
            state_d    = ST_BLOCK_START;
            word_cnt_d = '0;
        end else if (accept) begin
            if (at_start) every_d = timestamp_every;
            if (every_eff == '0 || cnt_inc == every_eff) begin
                state_d    = ST_BLOCK_START;
                word_cnt_d = '0;
            end else begin
                state_d    = ST_IN_BLOCK;
                word_cnt_d = cnt_inc;
            end
        end
    end

    // Sequencer registers and the registered overflow pulse.
    always_ff @(posedge adc_clk or negedge adc_resetn) begin
        if (!adc_resetn) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            every_q    <= '0;
            xfer_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            every_q    <= every_d;
            xfer_q     <= m_axis_xfer_req;
            overflow_q <= drop;
        end
    end

    assign fifo_wr_overflow = overflow_q;

    util_cpack2_timestamp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .CW         (CW)
    ) u_fifo (
        .clk_i      (adc_clk),
        .rst_ni     (adc_resetn),
        .flush_i    (state_q == ST_IDLE),
        .wr_cnt_i   (wr_cnt),
        .wr_data0_i (ins_ts ? DATA_WIDTH'(timestamp) : fifo_wr_data),
        .wr_data1_i (fifo_wr_data),
        .rd_en_i    (m_axis_ready),
        .valid_o    (m_axis_valid),
        .rd_data_o  (m_axis_data),
        .free_o     (free)
    );

`ifdef UTIL_CPACK2_TS_DROP_COUNT_EN
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

    // Saturating count of dropped input words, restarted at each transfer start.
    always_ff @(posedge adc_clk or negedge adc_resetn) begin
        if (!adc_resetn) begin
            drop_cnt_q <= '0;
        end else if (xfer_rise) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != '1) begin
            drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
        end
    end

    assign drop_count = drop_cnt_q;
`else
    // No drop counter in this build; the transfer-start edge is only used by the counter.
    logic unused_xfer_rise;
    assign unused_xfer_rise = xfer_rise;
`endif

endmodule
